// File: rtl/fetch_unit.sv
// Program counter and fetch stage feeding the instruction ROM; registers the fetched word for the decoder.
// Optional return-address link (call/ret ports, link_addr output) is enabled by defining FETCH_LINK_EN.
module fetch_unit #(
    parameter int                     ROM_SIZE    = 512,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 9'b111000000,
    localparam int                    AW          = $clog2(ROM_SIZE) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [AW-1:0]          branch_target,
`ifdef FETCH_LINK_EN
    input  logic                   call,
    input  logic                   ret,
    output logic [AW-1:0]          link_addr,
`endif
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [AW-1:0]          instr_addr,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   fault
);

    localparam logic [AW-1:0] ROM_LIMIT = AW'(ROM_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                   r_state;
    logic [AW-1:0]            r_pc_p0;
    logic [INSTR_WIDTH-1:0]   r_instr_p1;
    logic                     r_vld_p1;
    logic                     r_done;
    logic                     r_fault;
`ifdef FETCH_LINK_EN
    logic [AW-1:0]            r_link;
`endif

    logic                     w_target_ok;
    logic                     w_is_halt;
    logic                     w_at_end;

    assign w_target_ok = (branch_target < ROM_LIMIT);
    assign w_is_halt   = (instr_in == HALT_WORD);
    assign w_at_end    = (r_pc_p0 == LAST_ADDR);

    // Stage p0 -> p1: pc addresses the ROM, the returned word is captured into instr_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc_p0    <= '0;
            r_instr_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
`ifdef FETCH_LINK_EN
            r_link     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_pc_p0  <= '0;
                    r_vld_p1 <= 1'b0;
                    if (start) begin
                        r_done  <= 1'b0;
                        r_fault <= 1'b0;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (branch_taken) begin
                        // The word currently at pc belongs to the wrong path and is dropped.
                        r_vld_p1 <= 1'b0;
`ifdef FETCH_LINK_EN
                        if (call) begin
                            r_link <= r_pc_p0;
                        end
`endif
                        if (w_target_ok) begin
                            r_pc_p0 <= branch_target;
                        end else begin
                            r_fault <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= HALTED;
                        end
`ifdef FETCH_LINK_EN
                    end else if (ret) begin
                        r_pc_p0  <= r_link;
                        r_vld_p1 <= 1'b0;
`endif
                    end else if (stall) begin
                        r_pc_p0    <= r_pc_p0;
                    end else if (w_is_halt) begin
                        r_instr_p1 <= instr_in;
                        r_vld_p1   <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= HALTED;
                    end else begin
                        r_instr_p1 <= instr_in;
                        r_vld_p1   <= 1'b1;
                        // No wrap past the last ROM word: that is an address fault.
                        if (w_at_end) begin
                            r_fault <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= HALTED;
                        end else begin
                            r_pc_p0 <= r_pc_p0 + 1'b1;
                        end
                    end
                end

                HALTED: begin
                    r_vld_p1 <= 1'b0;
                    if (start) begin
                        r_done  <= 1'b0;
                        r_fault <= 1'b0;
                        r_pc_p0 <= '0;
                        r_state <= RUN;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_pc_p0  <= '0;
                    r_vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign instr_addr  = r_pc_p0;
    assign instr_out   = r_instr_p1;
    assign instr_valid = r_vld_p1;
    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign fault       = r_fault;
`ifdef FETCH_LINK_EN
    assign link_addr   = r_link;
`endif

endmodule
